// File: rtl/vga_pattern_gen.sv
// Frame pattern generator: one start pulse streams H_ACTIVE*V_ACTIVE pixels in
// raster order over a valid/ready handshake, with selectable test patterns.
module vga_pattern_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int V_ACTIVE  = 768,
    parameter int DATA_W    = 16,
    parameter int BAR_LOG2  = 7,
    parameter int CELL_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        mode_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              wr_en,
    output logic              data_en,
    output logic [DATA_W-1:0] dout,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int IW = $clog2(H_ACTIVE * V_ACTIVE);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [2:0]        mode_q;
    logic [DATA_W-1:0] color_q;
    logic [XW-1:0]     x, x_nxt;
    logic [YW-1:0]     y, y_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic              xfer, last_xfer;

    function automatic logic [DATA_W-1:0] pixel(
        input logic [2:0]        m,
        input logic [DATA_W-1:0] c,
        input logic [XW-1:0]     px,
        input logic [YW-1:0]     py,
        input logic [IW-1:0]     pi
    );
        logic bar_odd;
        logic cell_odd;
        bar_odd  = 1'(px >> BAR_LOG2);
        cell_odd = 1'(px >> CELL_LOG2) ^ 1'(py >> CELL_LOG2);
        case (m)
            3'd1:    pixel = DATA_W'(pi);
            3'd2:    pixel = bar_odd ? ~c : c;
            3'd3:    pixel = cell_odd ? ~c : c;
            3'd4:    pixel = DATA_W'(px);
            3'd5:    pixel = DATA_W'(py);
            default: pixel = c;
        endcase
    endfunction

    always_comb begin
        xfer      = data_en & wr_en;
        last_xfer = xfer && (x == X_LAST) && (y == Y_LAST);
        idx_nxt   = idx + 1'b1;
        x_nxt     = x + 1'b1;
        y_nxt     = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= '0;
            color_q     <= '0;
            x           <= '0;
            y           <= '0;
            idx         <= '0;
            data_en     <= 1'b0;
            dout        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            overrun_o   <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        mode_q  <= mode_i;
                        color_q <= color_i;
                        x       <= '0;
                        y       <= '0;
                        idx     <= '0;
                        // First pixel uses the incoming selection, not the stale latch
                        dout    <= pixel(mode_i, color_i, '0, '0, '0);
                        data_en <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_i)
                        overrun_o <= 1'b1;
                    if (last_xfer) begin
                        state       <= IDLE;
                        data_en     <= 1'b0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                        x           <= '0;
                        y           <= '0;
                        idx         <= '0;
                    end else if (xfer) begin
                        x    <= x_nxt;
                        y    <= y_nxt;
                        idx  <= idx_nxt;
                        dout <= pixel(mode_q, color_q, x_nxt, y_nxt, idx_nxt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on an 8x4 frame with 2-pixel bars and cells.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  mode_i = '0;
    logic [15:0] color_i = '0;
    logic        wr_en = 1'b0;
    logic        data_en;
    logic [15:0] dout;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [15:0] pix [0:63];
    int n_pix;
    int n_ov;
    int cyc;
    bit got_done;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE (8),
        .V_ACTIVE (4),
        .DATA_W   (16),
        .BAR_LOG2 (1),
        .CELL_LOG2(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .color_i    (color_i),
        .wr_en      (wr_en),
        .data_en    (data_en),
        .dout       (dout),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overrun_o  (overrun_o),
        .frame_cnt_o(frame_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel for raster index i of an 8x4 frame
    function automatic logic [15:0] exp_pix(input int m, input logic [15:0] c, input int i);
        int px;
        int py;
        px = i % 8;
        py = i / 8;
        case (m)
            1: return 16'(i);
            2: return (((px / 2) % 2) == 1) ? ~c : c;
            3: return ((((px / 2) ^ (py / 2)) % 2) == 1) ? ~c : c;
            4: return 16'(px);
            5: return 16'(py);
            default: return c;
        endcase
    endfunction

    task automatic start_frame(input int m, input logic [15:0] c);
        start_i = 1'b1;
        mode_i  = 3'(m);
        color_i = c;
        wr_en   = 1'b1;
        step();
        start_i = 1'b0;
        check("start_data_en", 32'(data_en), 32'd1);
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_first_pixel", 32'(dout), 32'(exp_pix(m, c, 0)));
    endtask

    // Runs the handshake until done_o; ov_a/ov_b are transfer numbers that get a stray start
    task automatic collect(input bit rnd, input int ov_a, input int ov_b);
        bit xfer;
        bit stall;
        logic [15:0] prev;
        n_pix = 0;
        n_ov = 0;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            wr_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer  = data_en && wr_en;
            stall = data_en && !wr_en;
            start_i = xfer && (n_pix == ov_a || n_pix == ov_b);
            if (start_i) begin
                mode_i  = 3'd4;
                color_i = 16'hAAAA;
            end
            prev = dout;
            if (xfer && n_pix < 64) begin
                pix[n_pix] = dout;
                n_pix++;
            end
            step();
            cyc++;
            start_i = 1'b0;
            if (overrun_o) n_ov++;
            if (stall) check("stall_hold", 32'(dout), 32'(prev));
            if (done_o) begin
                got_done = 1'b1;
                check("done_after_last", 32'(xfer), 32'd1);
                check("done_pix_count", 32'(n_pix), 32'd32);
                check("done_data_en_low", 32'(data_en), 32'd0);
                check("done_busy_low", 32'(busy_o), 32'd0);
            end
        end
        if (!got_done) check("frame_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int m, input logic [15:0] c);
        check({tag, "_count"}, 32'(n_pix), 32'd32);
        for (int i = 0; i < 32; i++)
            check(tag, 32'(pix[i]), 32'(exp_pix(m, c, i)));
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_data_en", 32'(data_en), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        rst = 1'b0;
        step();

        // SOLID, no stalls
        start_frame(0, 16'hF800);
        collect(1'b0, -1, -1);
        check_stream("solid", 0, 16'hF800);
        check("solid_cycles", 32'(cyc), 32'd32);
        check("solid_frame_cnt", 32'(frame_cnt_o), 32'd1);
        step();

        // COUNTER with random stalls
        start_frame(1, 16'h0000);
        collect(1'b1, -1, -1);
        for (int i = 0; i < 32; i++)
            check("counter_seq", 32'(pix[i]), 32'(i));
        check("counter_frame_cnt", 32'(frame_cnt_o), 32'd2);
        step();

        // VBARS
        start_frame(2, 16'h00FF);
        collect(1'b1, -1, -1);
        check("vbars_p0", 32'(pix[0]), 32'h00FF);
        check("vbars_p1", 32'(pix[1]), 32'h00FF);
        check("vbars_p2", 32'(pix[2]), 32'hFF00);
        check("vbars_p3", 32'(pix[3]), 32'hFF00);
        check_stream("vbars", 2, 16'h00FF);
        step();

        // CHECKER
        start_frame(3, 16'h00FF);
        collect(1'b0, -1, -1);
        check("checker_row2_p0", 32'(pix[16]), 32'hFF00);
        check("checker_row0_p2", 32'(pix[2]), 32'hFF00);
        check_stream("checker", 3, 16'h00FF);
        step();

        // Gradients and an undefined mode
        start_frame(4, 16'h1234);
        collect(1'b0, -1, -1);
        check_stream("xgrad", 4, 16'h1234);
        step();
        start_frame(5, 16'h1234);
        collect(1'b1, -1, -1);
        check_stream("ygrad", 5, 16'h1234);
        step();
        start_frame(7, 16'h5A5A);
        collect(1'b0, -1, -1);
        check_stream("mode7", 7, 16'h5A5A);
        check("frame_cnt_7", 32'(frame_cnt_o), 32'd7);
        step();

        // Overrun mid-frame and on the last transfer, then back-to-back start
        start_frame(1, 16'h0000);
        collect(1'b0, 10, 31);
        check("overrun_pulses", 32'(n_ov), 32'd2);
        check_stream("overrun_stream", 1, 16'h0000);
        start_frame(3, 16'h0F0F);
        collect(1'b0, -1, -1);
        check_stream("b2b_stream", 3, 16'h0F0F);
        check("b2b_frame_cnt", 32'(frame_cnt_o), 32'd9);
        step();

        // Reset after 10 transfers
        start_frame(1, 16'h0000);
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_dout", 32'(dout), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_data_en", 32'(data_en), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        n_pix = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_o || data_en) n_pix++;
        end
        check("midrst_no_activity", 32'(n_pix), 32'd0);
        check("midrst_cnt_after", 32'(frame_cnt_o), 32'd0);

        // Fresh frame after reset
        start_frame(1, 16'h0000);
        collect(1'b1, -1, -1);
        check_stream("post_rst_stream", 1, 16'h0000);
        check("post_rst_frame_cnt", 32'(frame_cnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised frame pattern generator feeding the SDRAM frame-buffer write path. One `start_i` pulse streams exactly `H_ACTIVE*V_ACTIVE` pixels, in raster order, through a valid/ready handshake into the memory arbiter's write port. The generator supports several selectable test patterns with configurable pixel width and resolution, an overrun flag and a completed-frame counter. It is the generalised successor of the fixed-depth frame data generator and sits between the frame-sync source and the frame-buffer write FIFO.

## Interface
- `H_ACTIVE`, default 1024: pixels per line, ≥2.
- `V_ACTIVE`, default 768: lines per frame, ≥2.
- `DATA_W`, default 16: pixel width in bits.
- `BAR_LOG2`, default 7: log2 of the vertical bar width in pixels.
- `CELL_LOG2`, default 5: log2 of the checker cell size in pixels.
- `clk` input 1: single clock for all logic.
- `rst` input 1: synchronous, active-high reset.
- `start_i` input 1: frame start pulse, one cycle.
- `mode_i` input 3: pattern select, latched on an accepted start.
- `color_i` input DATA_W: base colour, latched on an accepted start.
- `wr_en` input 1: downstream ready.
- `data_en` output 1: pixel valid.
- `dout` output DATA_W: pixel data.
- `busy_o` output 1: a frame is in progress.
- `done_o` output 1: one-cycle pulse after the last pixel transfers.
- `overrun_o` output 1: one-cycle pulse when a start is ignored.
- `frame_cnt_o` output 16: count of completed frames; wraps at 2^16.

## Operation
- FSM has two states, IDLE and RUN.
  - IDLE → RUN on `start_i`. On that edge: latch `mode_i` → `mode_q` and `color_i` → `color_q`, and clear x, y and the index counter.
  - RUN → IDLE on the transfer of pixel (H_ACTIVE-1, V_ACTIVE-1).
- Transfer definition: a transfer occurs in a cycle where `data_en && wr_en`.
- On each transfer: x increments. At x = H_ACTIVE-1, x wraps to 0 and y increments. The index counter (width clog2(H_ACTIVE*V_ACTIVE)) increments.
- Pixel function of (x, y, idx), computed for the next pixel and registered into `dout`:
  - 0 SOLID: `color_q`.
  - 1 COUNTER: idx, truncated or zero-extended to DATA_W.
  - 2 VBARS: `color_q` when bit 0 of (x >> BAR_LOG2) is 0, else `~color_q`.
  - 3 CHECKER: `color_q` when bit 0 of ((x >> CELL_LOG2) ^ (y >> CELL_LOG2)) is 0, else `~color_q`.
  - 4 XGRAD: x, truncated or zero-extended to DATA_W.
  - 5 YGRAD: y, truncated or zero-extended to DATA_W.
  - 6 and 7: treated as SOLID.
- Handshake: while `data_en` is high and `wr_en` is low, `dout`, x and y hold. `data_en` never drops mid-frame.
- `start_i` while in RUN is ignored: `overrun_o` pulses for 1 cycle and the frame continues unchanged. This includes a start in the same cycle as the last transfer.
- `frame_cnt_o` increments in the cycle `done_o` is asserted.

## Timing
- Reset values: state IDLE, `data_en` 0, `dout` 0, `busy_o` 0, `done_o` 0, `overrun_o` 0, `frame_cnt_o` 0, and all counters 0.
- `rst` has priority over everything else. Reset mid-frame aborts immediately: outputs take reset values on the next edge and no `done_o` is issued.
- Start latency: `start_i` high at edge n gives `data_en` = 1, `busy_o` = 1 and `dout` = pixel(0,0) after edge n.
- Throughput: one pixel per cycle while `wr_en` is held high. A frame takes H_ACTIVE*V_ACTIVE cycles plus stall cycles.
- End of frame: with the last transfer at edge m, after edge m `data_en` = 0, `busy_o` = 0, `done_o` = 1 and `frame_cnt_o` has incremented.
- Back-to-back frames: `start_i` at edge m+1 (the `done_o` cycle, state IDLE) is accepted, giving one idle cycle between frames.
- All outputs are registered. There is no combinational path from `wr_en` or `start_i` to any output.

## Test plan
- **SOLID, no stalls.** Setup: H=8, V=4, mode 0, colour 0xF800, `wr_en` = 1. Expect exactly 32 transfers of 0xF800 and `done_o` 1 cycle after the 32nd transfer. Expect `frame_cnt_o` = 1.
- **COUNTER with random stalls.** Setup: H=8, V=4, mode 1, `wr_en` random at 50%. Expect `dout` values 0..31 in order, no duplicates or gaps, and `dout` stable whenever a cycle stalls.
- **VBARS and CHECKER.** Setup: H=8, V=4, BAR_LOG2=1, CELL_LOG2=1, colour 0x00FF.
  - VBARS: line 0 is 00FF,00FF,FF00,FF00,…
  - CHECKER: row 2 starts with FF00.
- **Overrun and back-to-back.** Pulse `start_i` at mid-frame and again on the last-transfer cycle: expect 2 `overrun_o` pulses and an unchanged 32-pixel stream. Then pulse `start_i` in the `done_o` cycle: expect `data_en` high on the next cycle with pixel(0,0).
- **Reset mid-frame.** Assert `rst` after 10 transfers: expect all outputs 0 next cycle, no `done_o`, and `frame_cnt_o` = 0. A fresh start then produces a full 32-pixel frame.
